// File: rtl/cpu_seq_ctrl_if.sv
// Instruction / serial-ALU bus between the issuing CPU front end (master)
// and the bit-serial sequencing controller (slave).
interface cpu_seq_ctrl_if;
  // Instruction issue
  logic        instr_valid;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        instr_drop;
  // Serial ALU feedback
  logic        alu_res_bit;
  logic        alu_cout;
  // Sequencing status
  logic        busy;
  logic        done;
  logic        illegal;
  // Datapath control
  logic        shift_en;
  logic [2:0]  bit_idx;
  logic [2:0]  alu_op;
  logic        carry_init;
  logic        b_sel;
  logic        imm_bit;
  logic [1:0]  rd_sel;
  logic [1:0]  rs_sel;
  logic        wb_en;
  logic        out_load;
  // Status flags
  logic        carry_flag;
  logic        zero_flag;

  modport master (
    output instr_valid, opcode, instr, alu_res_bit, alu_cout,
    input  instr_drop, busy, done, illegal, shift_en, bit_idx, alu_op,
           carry_init, b_sel, imm_bit, rd_sel, rs_sel, wb_en, out_load,
           carry_flag, zero_flag
  );

  modport slave (
    input  instr_valid, opcode, instr, alu_res_bit, alu_cout,
    output instr_drop, busy, done, illegal, shift_en, bit_idx, alu_op,
           carry_init, b_sel, imm_bit, rd_sel, rs_sel, wb_en, out_load,
           carry_flag, zero_flag
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Bit-serial CPU sequencing controller: latches one instruction, walks the
// serial ALU LSB-first over 8 bits, then commits the result (or loads the
// output register) and signals completion. Flags are captured on the last bit.
module cpu_seq_ctrl (
  input  logic          clk,
  input  logic          rst_n,
  cpu_seq_ctrl_if.slave bus
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_OUT  = 4'd8;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [11:0] instr_q, instr_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic        carry_flag_q, carry_flag_d;
  logic        zero_flag_q, zero_flag_d;
  // Running "all result bits so far were zero" for the current EXEC pass
  logic        zero_acc_q, zero_acc_d;

  // Decoded properties of the latched opcode
  logic        is_alu;      // opcodes that write rd
  logic        is_out;
  logic        is_legal;
  logic        is_illegal;
  logic        carry_upd;   // carry_flag follows alu_cout on the last bit
  logic [2:0]  alu_op_c;
  logic        b_sel_c;
  logic        carry_init_c;

  // FSM-driven strobes
  logic        shift_en_c;
  logic        wb_en_c;
  logic        out_load_c;
  logic        done_c;
  logic        illegal_c;
  logic        imm_bit_c;

  logic [7:0]  imm8;
  logic        busy_c;

  assign imm8   = instr_q[11:4];
  assign busy_c = (state_q != S_IDLE);

  // State, latched instruction, bit counter and flags; reset clears all of it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      opcode_q     <= 4'd0;
      instr_q      <= 12'd0;
      bit_idx_q    <= 3'd0;
      carry_flag_q <= 1'b0;
      zero_flag_q  <= 1'b0;
      zero_acc_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      instr_q      <= instr_d;
      bit_idx_q    <= bit_idx_d;
      carry_flag_q <= carry_flag_d;
      zero_flag_q  <= zero_flag_d;
      zero_acc_q   <= zero_acc_d;
    end
  end

  // Opcode decode into ALU function, operand-B source and carry preset
  always_comb begin
    is_alu       = (opcode_q >= OP_ADD) && (opcode_q <= OP_ADDI);
    is_out       = (opcode_q == OP_OUT);
    is_legal     = is_alu || is_out;
    is_illegal   = (opcode_q > OP_OUT);
    alu_op_c     = ALU_ADD;
    b_sel_c      = 1'b0;
    carry_init_c = 1'b0;
    carry_upd    = 1'b0;
    case (opcode_q)
      OP_ADD: begin
        alu_op_c  = ALU_ADD;
        carry_upd = 1'b1;
      end
      OP_SUB: begin
        // Two's-complement subtract: invert B in the ALU, carry-in of 1
        alu_op_c     = ALU_SUB;
        carry_init_c = 1'b1;
        carry_upd    = 1'b1;
      end
      OP_AND:  alu_op_c = ALU_AND;
      OP_OR:   alu_op_c = ALU_OR;
      OP_XOR:  alu_op_c = ALU_XOR;
      OP_LDI: begin
        alu_op_c = ALU_PASSB;
        b_sel_c  = 1'b1;
      end
      OP_ADDI: begin
        alu_op_c  = ALU_ADD;
        b_sel_c   = 1'b1;
        carry_upd = 1'b1;
      end
      OP_OUT: begin
        // rd is routed through B (rs_sel forced to rd) so it recirculates
        alu_op_c = ALU_PASSB;
        b_sel_c  = 1'b0;
      end
      default: begin
        alu_op_c = ALU_ADD;
      end
    endcase
  end

  // Next-state, datapath strobes and flag updates
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    instr_d      = instr_q;
    bit_idx_d    = bit_idx_q;
    carry_flag_d = carry_flag_q;
    zero_flag_d  = zero_flag_q;
    zero_acc_d   = zero_acc_q;
    shift_en_c   = 1'b0;
    wb_en_c      = 1'b0;
    out_load_c   = 1'b0;
    done_c       = 1'b0;
    illegal_c    = 1'b0;
    imm_bit_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          opcode_d = bus.opcode;
          instr_d  = bus.instr;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        bit_idx_d  = 3'd0;
        zero_acc_d = 1'b1;
        state_d    = is_legal ? S_EXEC : S_DONE;
      end
      S_EXEC: begin
        shift_en_c = 1'b1;
        imm_bit_c  = imm8[bit_idx_q];
        zero_acc_d = zero_acc_q & ~bus.alu_res_bit;
        bit_idx_d  = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) begin
          // Last bit: the current result bit still counts toward zero
          if (carry_upd) begin
            carry_flag_d = bus.alu_cout;
          end
          if (is_alu) begin
            zero_flag_d = zero_acc_q & ~bus.alu_res_bit;
          end
          bit_idx_d = 3'd0;
          state_d   = S_WB;
        end
      end
      S_WB: begin
        wb_en_c    = is_alu;
        out_load_c = is_out;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done_c    = 1'b1;
        illegal_c = is_illegal;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output drive; decode fields come from the latched (reset-cleared) opcode
  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.illegal    = illegal_c;
  assign bus.instr_drop = bus.instr_valid && busy_c;
  assign bus.shift_en   = shift_en_c;
  assign bus.bit_idx    = bit_idx_q;
  assign bus.alu_op     = alu_op_c;
  assign bus.carry_init = carry_init_c;
  assign bus.b_sel      = b_sel_c;
  assign bus.imm_bit    = imm_bit_c;
  assign bus.rd_sel     = instr_q[1:0];
  assign bus.rs_sel     = is_out ? instr_q[1:0] : instr_q[3:2];
  assign bus.wb_en      = wb_en_c;
  assign bus.out_load   = out_load_c;
  assign bus.carry_flag = carry_flag_q;
  assign bus.zero_flag  = zero_flag_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed, table-driven bench for cpu_seq_ctrl plus hand-written overrun
// and mid-operation reset sequences.
module tb_cpu_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cpu_seq_ctrl_if bus ();

  cpu_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [11:0] ins;
    logic [7:0] res;    // alu_res_bit pattern, bit i driven at EXEC bit i
    logic       cout;   // alu_cout driven at bit 7
    int         lat;    // cycles from instr_valid to done
    int         shifts;
    int         wbs;
    int         outs;
    logic       ill;
    logic [2:0] aop;
    logic       bsel;
    logic       cinit;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;    // expected imm_bit sequence, LSB first
    logic       cf;     // carry_flag after completion
    logic       zf;     // zero_flag after completion
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input string name, input logic [3:0] op,
      input logic [11:0] ins, input logic [7:0] res, input logic cout,
      input int lat, input int shifts, input int wbs, input int outs,
      input logic ill, input logic [2:0] aop, input logic bsel,
      input logic cinit, input logic [1:0] rd, input logic [1:0] rs,
      input logic [7:0] imm, input logic cf, input logic zf);
    vec_t v;
    v.name = name; v.op = op; v.ins = ins; v.res = res; v.cout = cout;
    v.lat = lat; v.shifts = shifts; v.wbs = wbs; v.outs = outs; v.ill = ill;
    v.aop = aop; v.bsel = bsel; v.cinit = cinit; v.rd = rd; v.rs = rs;
    v.imm = imm; v.cf = cf; v.zf = zf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Issue one instruction (caller is at a falling edge) and check it through
  // completion. Returns at the falling edge of the first cycle back in IDLE.
  task automatic run_vec(input vec_t v);
    int k;
    int done_k, wb_k, out_k, shift_n, wb_n, out_n, busy_n, drop_n;
    int bit_err, stray_imm;
    logic ill_at_done;
    logic [7:0] imm_acc;
    done_k = 0; wb_k = 0; out_k = 0; shift_n = 0; wb_n = 0; out_n = 0;
    busy_n = 0; drop_n = 0; bit_err = 0; stray_imm = 0; ill_at_done = 1'b0;
    imm_acc = 8'h00;
    bus.instr_valid = 1'b1;
    bus.opcode      = v.op;
    bus.instr       = v.ins;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    k = 1;
    while (done_k == 0 && k < 20) begin
      if (k >= 2 && k <= 9) begin
        bus.alu_res_bit = v.res[k-2];
        bus.alu_cout    = (k == 9) ? v.cout : 1'b0;
      end else begin
        bus.alu_res_bit = 1'b0;
        bus.alu_cout    = 1'b0;
      end
      #1;
      if (bus.busy) busy_n++;
      if (bus.instr_drop) drop_n++;
      if (bus.shift_en) begin
        shift_n++;
        if (k < 2 || k > 9 || bus.bit_idx != 3'(k - 2)) bit_err++;
      end
      if (k >= 2 && k <= 9) imm_acc[k-2] = bus.imm_bit;
      else if (bus.imm_bit) stray_imm++;
      if (bus.wb_en) begin wb_n++; wb_k = k; end
      if (bus.out_load) begin out_n++; out_k = k; end
      if (k == 2 && v.shifts > 0) begin
        chk({v.name, " alu_op"}, 32'(bus.alu_op), 32'(v.aop));
        chk({v.name, " b_sel"}, 32'(bus.b_sel), 32'(v.bsel));
        chk({v.name, " carry_init"}, 32'(bus.carry_init), 32'(v.cinit));
        chk({v.name, " rd_sel"}, 32'(bus.rd_sel), 32'(v.rd));
        chk({v.name, " rs_sel"}, 32'(bus.rs_sel), 32'(v.rs));
      end
      if (bus.done) begin
        done_k = k;
        ill_at_done = bus.illegal;
      end else if (bus.illegal) begin
        bit_err++;
      end
      @(negedge clk);
      k++;
    end
    #1;
    chk({v.name, " done_latency"}, 32'(done_k), 32'(v.lat));
    chk({v.name, " illegal"}, 32'(ill_at_done), 32'(v.ill));
    chk({v.name, " busy_cycles"}, 32'(busy_n), 32'(v.lat));
    chk({v.name, " shift_cycles"}, 32'(shift_n), 32'(v.shifts));
    chk({v.name, " bit_seq_errs"}, 32'(bit_err), 32'd0);
    chk({v.name, " wb_count"}, 32'(wb_n), 32'(v.wbs));
    chk({v.name, " wb_time"}, 32'(wb_k), (v.wbs > 0) ? 32'd10 : 32'd0);
    chk({v.name, " out_count"}, 32'(out_n), 32'(v.outs));
    chk({v.name, " out_time"}, 32'(out_k), (v.outs > 0) ? 32'd10 : 32'd0);
    chk({v.name, " imm_seq"}, 32'(imm_acc), 32'(v.imm));
    chk({v.name, " imm_stray"}, 32'(stray_imm), 32'd0);
    chk({v.name, " drop"}, 32'(drop_n), 32'd0);
    chk({v.name, " idle_after"}, 32'(bus.busy), 32'd0);
    chk({v.name, " carry_flag"}, 32'(bus.carry_flag), 32'(v.cf));
    chk({v.name, " zero_flag"}, 32'(bus.zero_flag), 32'(v.zf));
    $display("txn %s op=%0d instr=%03h: done at T+%0d shifts=%0d wb=%0d out=%0d cf=%0b zf=%0b",
             v.name, v.op, v.ins, done_k, shift_n, wb_n, out_n,
             bus.carry_flag, bus.zero_flag);
  endtask

  initial begin
    int k;
    int drop_n, wb_n;
    logic done_seen;
    //            name    op    instr   res    co lat sh wb out ill aop  bs ci rd rs imm    cf zf
    vecs[0] = mk("ADD",  4'd1, 12'h004, 8'h00, 1, 11, 8, 1, 0, 0, 3'd0, 0, 0, 0, 1, 8'h00, 1, 1);
    vecs[1] = mk("LDI",  4'd6, 12'hA51, 8'hA5, 0, 11, 8, 1, 0, 0, 3'd5, 1, 0, 1, 0, 8'hA5, 1, 0);
    vecs[2] = mk("ILL",  4'hC, 12'h000, 8'h00, 0,  2, 0, 0, 0, 1, 3'd0, 0, 0, 0, 0, 8'h00, 1, 0);
    vecs[3] = mk("SUB",  4'd2, 12'h00E, 8'h00, 0, 11, 8, 1, 0, 0, 3'd1, 0, 1, 2, 3, 8'h00, 0, 1);
    vecs[4] = mk("AND",  4'd3, 12'h009, 8'h01, 1, 11, 8, 1, 0, 0, 3'd2, 0, 0, 1, 2, 8'h00, 0, 0);
    vecs[5] = mk("OUT",  4'd8, 12'h002, 8'h00, 1, 11, 8, 0, 1, 0, 3'd5, 0, 0, 2, 2, 8'h00, 0, 0);
    vecs[6] = mk("NOP",  4'd0, 12'h000, 8'h00, 0,  2, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'h00, 0, 0);
    vecs[7] = mk("ADDI", 4'd7, 12'h3C3, 8'h10, 1, 11, 8, 1, 0, 0, 3'd0, 1, 0, 3, 0, 8'h3C, 1, 0);
    vecs[8] = mk("XOR",  4'd5, 12'h00C, 8'h00, 0, 11, 8, 1, 0, 0, 3'd4, 0, 0, 0, 3, 8'h00, 1, 1);
    vecs[9] = mk("OR",   4'd4, 12'h006, 8'h80, 0, 11, 8, 1, 0, 0, 3'd3, 0, 0, 2, 1, 8'h00, 1, 0);

    bus.instr_valid = 1'b0;
    bus.opcode      = 4'd0;
    bus.instr       = 12'd0;
    bus.alu_res_bit = 1'b0;
    bus.alu_cout    = 1'b0;

    // Reset state
    #1;
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst done", 32'(bus.done), 32'd0);
    chk("rst shift_en", 32'(bus.shift_en), 32'd0);
    chk("rst bit_idx", 32'(bus.bit_idx), 32'd0);
    chk("rst flags", 32'({bus.carry_flag, bus.zero_flag}), 32'd0);
    chk("rst selects", 32'({bus.rd_sel, bus.rs_sel, bus.alu_op}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Table: first entry issued on the very first edge after reset release
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Overrun: a second instruction during EXEC is dropped
    drop_n = 0;
    done_seen = 1'b0;
    bus.instr_valid = 1'b1;
    bus.opcode      = 4'd1;
    bus.instr       = 12'h004;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    for (int kk = 1; kk < 20 && !done_seen; kk++) begin
      bus.alu_res_bit = 1'b0;
      bus.alu_cout    = (kk == 9);
      bus.instr_valid = (kk == 4);
      bus.opcode      = (kk == 4) ? 4'd2 : 4'd1;
      bus.instr       = (kk == 4) ? 12'hFFF : 12'h004;
      #1;
      if (bus.instr_drop) drop_n++;
      if (kk == 4) chk("ovr drop_pulse", 32'(bus.instr_drop), 32'd1);
      if (kk == 6) begin
        chk("ovr alu_op", 32'(bus.alu_op), 32'd0);
        chk("ovr sel", 32'({bus.rd_sel, bus.rs_sel}), 32'({2'd0, 2'd1}));
        chk("ovr carry_init", 32'(bus.carry_init), 32'd0);
      end
      if (kk == 10) chk("ovr wb_en", 32'(bus.wb_en), 32'd1);
      if (bus.done) begin
        done_seen = 1'b1;
        chk("ovr done_latency", 32'(kk), 32'd11);
      end
      @(negedge clk);
      bus.instr_valid = 1'b0;
    end
    chk("ovr done_seen", 32'(done_seen), 32'd1);
    chk("ovr drop_count", 32'(drop_n), 32'd1);
    #1;
    chk("ovr flags", 32'({bus.carry_flag, bus.zero_flag}), 32'b11);
    $display("txn OVERRUN: drops=%0d cf=%0b zf=%0b", drop_n, bus.carry_flag, bus.zero_flag);

    // Reset at bit_idx=4 in the middle of an ADDI
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.opcode      = 4'd7;
    bus.instr       = 12'h3C3;
    @(negedge clk);
    bus.instr_valid = 1'b0;
    k = 1;
    while (k < 6) begin
      @(negedge clk);
      k++;
    end
    #1;
    chk("rstmid pre bit_idx", 32'(bus.bit_idx), 32'd4);
    chk("rstmid pre shift_en", 32'(bus.shift_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid busy", 32'(bus.busy), 32'd0);
    chk("rstmid shift_en", 32'(bus.shift_en), 32'd0);
    chk("rstmid ctrl", 32'({bus.bit_idx, bus.alu_op, bus.b_sel, bus.imm_bit, bus.rd_sel}), 32'd0);
    chk("rstmid flags", 32'({bus.carry_flag, bus.zero_flag}), 32'd0);
    wb_n = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (bus.wb_en || bus.done || bus.busy) wb_n++;
    end
    chk("rstmid no_activity", 32'(wb_n), 32'd0);
    $display("txn RESET_MID: busy=%0b flags=%0b%0b", bus.busy, bus.carry_flag, bus.zero_flag);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
